// File: rtl/us_burst_tx.sv
// Ultrasonic burst transmitter: complementary 40 kHz drive bursts framed by
// a ringing blank window, repeated back-to-back while enabled or single-shot on trig.
module us_burst_tx #(
    parameter int HALF_PERIOD  = 625,
    parameter int BURST_CYCLES = 8,
    parameter int BLANK_CYCLES = 50000,
    parameter int FRAME_CYCLES = 3000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic trig,
    output logic tx_p,
    output logic tx_n,
    output logic pulse_t,
    output logic blank,
    output logic busy,
    output logic frame_done
);

    localparam int HW = (HALF_PERIOD  > 1) ? $clog2(HALF_PERIOD)  : 1;
    localparam int CW = $clog2(BURST_CYCLES + 1);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] CYCLE_LAST = CW'(BURST_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_BLANK,
        S_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [HW-1:0] r_halfCnt,  w_halfNext;
    logic          r_phase,    w_phaseNext;
    logic [CW-1:0] r_cycleCnt, w_cycleNext;
    logic [BW-1:0] r_blankCnt, w_blankNext;
    logic [FW-1:0] r_frameCnt, w_frameNext;
    logic          w_start;

    logic r_txP, r_txN, r_pulse, r_blank, r_busy, r_frameDone;

    // Next-state and counter logic; r_phase selects the high/low half of a carrier cycle.
    always_comb begin
        w_stateNext = r_state;
        w_halfNext  = r_halfCnt;
        w_phaseNext = r_phase;
        w_cycleNext = r_cycleCnt;
        w_blankNext = r_blankCnt;
        w_frameNext = r_frameCnt + FW'(1);
        w_start     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_frameNext = r_frameCnt;
                if (en || trig) begin
                    w_start = 1'b1;
                end
            end
            S_BURST: begin
                if (r_halfCnt == HALF_LAST) begin
                    w_halfNext  = '0;
                    w_phaseNext = ~r_phase;
                    if (r_phase) begin
                        if (r_cycleCnt == CYCLE_LAST) begin
                            w_stateNext = S_BLANK;
                            w_blankNext = '0;
                        end else begin
                            w_cycleNext = r_cycleCnt + CW'(1);
                        end
                    end
                end else begin
                    w_halfNext = r_halfCnt + HW'(1);
                end
            end
            S_BLANK: begin
                if (r_blankCnt == BLANK_LAST) begin
                    w_stateNext = S_WAIT;
                end else begin
                    w_blankNext = r_blankCnt + BW'(1);
                end
            end
            S_WAIT: begin
                if (r_frameCnt == FRAME_LAST) begin
                    if (en) begin
                        w_start = 1'b1;
                    end else begin
                        w_stateNext = S_IDLE;
                        w_frameNext = r_frameCnt;
                    end
                end
            end
            default: w_stateNext = S_IDLE;
        endcase

        // A new frame restarts every counter so the period is exactly FRAME_CYCLES.
        if (w_start) begin
            w_stateNext = S_BURST;
            w_halfNext  = '0;
            w_phaseNext = 1'b0;
            w_cycleNext = '0;
            w_blankNext = '0;
            w_frameNext = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_halfCnt  <= '0;
            r_phase    <= 1'b0;
            r_cycleCnt <= '0;
            r_blankCnt <= '0;
            r_frameCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_halfCnt  <= w_halfNext;
            r_phase    <= w_phaseNext;
            r_cycleCnt <= w_cycleNext;
            r_blankCnt <= w_blankNext;
            r_frameCnt <= w_frameNext;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_txP       <= 1'b0;
            r_txN       <= 1'b0;
            r_pulse     <= 1'b0;
            r_blank     <= 1'b0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_txP       <= (w_stateNext == S_BURST) && !w_phaseNext;
            r_txN       <= (w_stateNext == S_BURST) &&  w_phaseNext;
            r_pulse     <= (w_stateNext == S_BURST);
            r_blank     <= (w_stateNext == S_BURST) || (w_stateNext == S_BLANK);
            r_busy      <= (w_stateNext != S_IDLE);
            r_frameDone <= (w_stateNext != S_IDLE) && (w_frameNext == FRAME_LAST);
        end
    end

    assign tx_p       = r_txP;
    assign tx_n       = r_txN;
    assign pulse_t    = r_pulse;
    assign blank      = r_blank;
    assign busy       = r_busy;
    assign frame_done = r_frameDone;

endmodule
